// File: rtl/zx_kbd_pkg.sv
// Shared types and constants for the ZX Spectrum keyboard matrix block.
package zx_kbd_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 5;
    localparam int NKEYS = ROWS * COLS;
    localparam int NVIRT = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BRK     = 3'd1,
        S_EXT     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_SKIP    = 3'd4
    } kbd_state_t;

    // Set-2 prefixes and keyboard-to-host status bytes.
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_AA     = 8'hAA;
    localparam logic [7:0] SC_FA     = 8'hFA;
    localparam logic [7:0] SC_EE     = 8'hEE;
    localparam logic [7:0] SC_FE     = 8'hFE;
    localparam logic [7:0] SC_00     = 8'h00;
    localparam logic [7:0] SC_FF     = 8'hFF;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Key index = row*5 + col, column 0 is the key nearest the edge of the half-row.
    localparam logic [5:0] K_CS  = 6'd0,  K_Z  = 6'd1,  K_X  = 6'd2,  K_C  = 6'd3,  K_V  = 6'd4;
    localparam logic [5:0] K_A   = 6'd5,  K_S  = 6'd6,  K_D  = 6'd7,  K_F  = 6'd8,  K_G  = 6'd9;
    localparam logic [5:0] K_Q   = 6'd10, K_W  = 6'd11, K_E  = 6'd12, K_R  = 6'd13, K_T  = 6'd14;
    localparam logic [5:0] K_1   = 6'd15, K_2  = 6'd16, K_3  = 6'd17, K_4  = 6'd18, K_5  = 6'd19;
    localparam logic [5:0] K_0   = 6'd20, K_9  = 6'd21, K_8  = 6'd22, K_7  = 6'd23, K_6  = 6'd24;
    localparam logic [5:0] K_P   = 6'd25, K_O  = 6'd26, K_I  = 6'd27, K_U  = 6'd28, K_Y  = 6'd29;
    localparam logic [5:0] K_ENT = 6'd30, K_L  = 6'd31, K_K  = 6'd32, K_J  = 6'd33, K_H  = 6'd34;
    localparam logic [5:0] K_SPC = 6'd35, K_SS = 6'd36, K_M  = 6'd37, K_N  = 6'd38, K_B  = 6'd39;

    // Virtual combo slots: each one presses CAPS SHIFT plus one digit.
    localparam logic [2:0] V_LEFT  = 3'd0;  // CS+5
    localparam logic [2:0] V_DOWN  = 3'd1;  // CS+6
    localparam logic [2:0] V_UP    = 3'd2;  // CS+7
    localparam logic [2:0] V_RIGHT = 3'd3;  // CS+8
    localparam logic [2:0] V_BKSP  = 3'd4;  // CS+0

    // Merge physical keys with the virtual combos into the matrix the CPU sees.
    function automatic logic [NKEYS-1:0] eff_keys(input logic [NKEYS-1:0] phys,
                                                  input logic [NVIRT-1:0] virt);
        logic [NKEYS-1:0] e;
        e        = phys;
        e[K_CS]  = e[K_CS] | (|virt);
        e[K_5]   = e[K_5]  | virt[V_LEFT];
        e[K_6]   = e[K_6]  | virt[V_DOWN];
        e[K_7]   = e[K_7]  | virt[V_UP];
        e[K_8]   = e[K_8]  | virt[V_RIGHT];
        e[K_0]   = e[K_0]  | virt[V_BKSP];
        return e;
    endfunction

endpackage

// File: rtl/zx_scancode_map.sv
// Combinational set-2 scancode to Spectrum matrix lookup.
// A hit either names a physical key (idx_o) or a virtual combo slot (combo_o, vidx_o).
module zx_scancode_map
    import zx_kbd_pkg::*;
#(
    parameter bit EXT_COMBOS = 1'b1
) (
    input  logic       ext_i,
    input  logic [7:0] code_i,
    output logic       hit_o,
    output logic [5:0] idx_o,
    output logic       combo_o,
    output logic [2:0] vidx_o
);

    // Decode the byte; hit defaults high and is dropped by the default arm.
    always_comb begin
        hit_o   = 1'b1;
        idx_o   = 6'd0;
        combo_o = 1'b0;
        vidx_o  = 3'd0;
        if (!ext_i) begin
            case (code_i)
                8'h12: idx_o = K_CS;
                8'h1A: idx_o = K_Z;
                8'h22: idx_o = K_X;
                8'h21: idx_o = K_C;
                8'h2A: idx_o = K_V;
                8'h1C: idx_o = K_A;
                8'h1B: idx_o = K_S;
                8'h23: idx_o = K_D;
                8'h2B: idx_o = K_F;
                8'h34: idx_o = K_G;
                8'h15: idx_o = K_Q;
                8'h1D: idx_o = K_W;
                8'h24: idx_o = K_E;
                8'h2D: idx_o = K_R;
                8'h2C: idx_o = K_T;
                8'h16: idx_o = K_1;
                8'h1E: idx_o = K_2;
                8'h26: idx_o = K_3;
                8'h25: idx_o = K_4;
                8'h2E: idx_o = K_5;
                8'h45: idx_o = K_0;
                8'h46: idx_o = K_9;
                8'h3E: idx_o = K_8;
                8'h3D: idx_o = K_7;
                8'h36: idx_o = K_6;
                8'h4D: idx_o = K_P;
                8'h44: idx_o = K_O;
                8'h43: idx_o = K_I;
                8'h3C: idx_o = K_U;
                8'h35: idx_o = K_Y;
                8'h5A: idx_o = K_ENT;
                8'h4B: idx_o = K_L;
                8'h42: idx_o = K_K;
                8'h3B: idx_o = K_J;
                8'h33: idx_o = K_H;
                8'h29: idx_o = K_SPC;
                8'h59: idx_o = K_SS;
                8'h3A: idx_o = K_M;
                8'h31: idx_o = K_N;
                8'h32: idx_o = K_B;
                8'h66: begin
                    hit_o   = EXT_COMBOS;
                    combo_o = EXT_COMBOS;
                    vidx_o  = V_BKSP;
                end
                default: hit_o = 1'b0;
            endcase
        end else begin
            case (code_i)
                8'h5A: idx_o = K_ENT;
                8'h14: idx_o = K_SS;
                8'h6B: begin
                    hit_o   = EXT_COMBOS;
                    combo_o = EXT_COMBOS;
                    vidx_o  = V_LEFT;
                end
                8'h72: begin
                    hit_o   = EXT_COMBOS;
                    combo_o = EXT_COMBOS;
                    vidx_o  = V_DOWN;
                end
                8'h75: begin
                    hit_o   = EXT_COMBOS;
                    combo_o = EXT_COMBOS;
                    vidx_o  = V_UP;
                end
                8'h74: begin
                    hit_o   = EXT_COMBOS;
                    combo_o = EXT_COMBOS;
                    vidx_o  = V_RIGHT;
                end
                default: hit_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/zx_kbd_matrix.sv
// ZX Spectrum keyboard matrix fed by a PS/2 set-2 byte stream, read via port xxFE.
//
// state     | meaning
// S_IDLE    | no prefix pending; next mapped byte is a make
// S_BRK     | F0 seen; next mapped byte is a break
// S_EXT     | E0 seen; next byte uses the extended map
// S_EXT_BRK | E0 F0 seen; next byte is an extended break
// S_SKIP    | discarding the tail of a Pause (E1) sequence
module zx_kbd_matrix
    import zx_kbd_pkg::*;
#(
    parameter int IDLE_CLR_CYCLES = 0,
    parameter int CNT_W           = 32,
    parameter bit EXT_COMBOS      = 1'b1,
    parameter bit EAR_LEGACY      = 1'b1,
    parameter int PAUSE_SKIP      = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              ce,
    input  logic              rd,
    input  logic [15:0]       ad,
    input  logic              aud_in,
    output logic [7:0]        rd_data,
    output logic [NKEYS-1:0]  keys
);

    kbd_state_t        state_q, state_d;
    logic [7:0]        skip_q, skip_d;
    logic [NKEYS-1:0]  phys_q, phys_d;
    logic [NVIRT-1:0]  virt_q, virt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rx_ready_q;

    logic              acc;
    logic              map_ext;
    logic              map_hit;
    logic [5:0]        map_idx;
    logic              map_combo;
    logic [2:0]        map_vidx;
    logic              do_set;
    logic              do_clr;
    logic              idle_hit;
    logic [NKEYS-1:0]  eff;
    logic [COLS-1:0]   row_or;
    logic              unused_ad_lo;

    assign acc          = rx_valid & rx_ready_q;
    assign rx_ready     = rx_ready_q;
    assign eff          = eff_keys(phys_q, virt_q);
    assign keys         = eff;
    assign map_ext      = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    assign unused_ad_lo = ^ad[7:0];

    zx_scancode_map #(
        .EXT_COMBOS (EXT_COMBOS)
    ) u_map (
        .ext_i   (map_ext),
        .code_i  (rx_data),
        .hit_o   (map_hit),
        .idx_o   (map_idx),
        .combo_o (map_combo),
        .vidx_o  (map_vidx)
    );

    // Idle-clear fires only on a cycle with no accepted byte, so a byte on that cycle wins.
    assign idle_hit = (IDLE_CLR_CYCLES > 0) && !acc &&
                      (cnt_q == CNT_W'(IDLE_CLR_CYCLES - 1)) && (|eff);

    // Idle counter: restarts on every accepted byte, otherwise counts up and saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (acc) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prefix FSM and key-vector updates for each accepted byte.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        phys_d  = phys_q;
        virt_d  = virt_q;
        do_set  = 1'b0;
        do_clr  = 1'b0;
        if (acc) begin
            case (state_q)
                S_IDLE: begin
                    case (rx_data)
                        SC_F0: state_d = S_BRK;
                        SC_E0: state_d = S_EXT;
                        SC_E1: begin
                            if (PAUSE_SKIP > 0) begin
                                state_d = S_SKIP;
                                skip_d  = 8'(PAUSE_SKIP);
                            end
                        end
                        SC_AA: begin
                            phys_d = '0;
                            virt_d = '0;
                        end
                        SC_FA, SC_EE, SC_FE, SC_00, SC_FF: ;
                        default: do_set = 1'b1;
                    endcase
                end
                S_BRK: begin
                    do_clr  = 1'b1;
                    state_d = S_IDLE;
                end
                S_EXT: begin
                    if (rx_data == SC_F0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        state_d = S_IDLE;
                        // Fake shifts and nested prefixes are dropped without touching keys.
                        if (!(rx_data == SC_E0 || rx_data == SC_E1 ||
                              rx_data == SC_LSHIFT || rx_data == SC_RSHIFT)) begin
                            do_set = 1'b1;
                        end
                    end
                end
                S_EXT_BRK: begin
                    do_clr  = 1'b1;
                    state_d = S_IDLE;
                end
                S_SKIP: begin
                    if (skip_q <= 8'd1) begin
                        skip_d  = 8'd0;
                        state_d = S_IDLE;
                    end else begin
                        skip_d = skip_q - 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (map_hit && (do_set || do_clr)) begin
            if (map_combo) begin
                virt_d[map_vidx] = do_set;
            end else begin
                phys_d[map_idx] = do_set;
            end
        end
        if (idle_hit) begin
            phys_d = '0;
            virt_d = '0;
        end
    end

    // State, key vectors and counters; async reset drops any pending prefix.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            skip_q     <= 8'd0;
            phys_q     <= '0;
            virt_q     <= '0;
            cnt_q      <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            phys_q     <= phys_d;
            virt_q     <= virt_d;
            cnt_q      <= cnt_d;
            rx_ready_q <= 1'b1;
        end
    end

    // OR together every half-row whose address line is low.
    always_comb begin
        row_or = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!ad[8+r]) begin
                row_or = row_or | eff[r*COLS +: COLS];
            end
        end
    end

    // Port xxFE read value; bits 7:5 carry EAR in either the legacy or the issue-3 layout.
    always_comb begin
        rd_data = 8'hFF;
        if (ce && rd) begin
            rd_data[4:0] = ~row_or;
            if (EAR_LEGACY) begin
                rd_data[7] = aud_in;
                rd_data[5] = aud_in;
            end else begin
                rd_data[6] = aud_in;
            end
        end
    end

endmodule

// File: tb/tb_zx_kbd_matrix.sv
// Self-checking bench: two instances (default, and idle-clear with issue-3 EAR layout)
// compared against a flag-based reference model of the PS/2 to matrix rules.
module tb_zx_kbd_matrix;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        ce;
    logic        rd;
    logic [15:0] ad;
    logic        aud_in;
    logic        rx_ready_a, rx_ready_b;
    logic [7:0]  rd_data_a, rd_data_b;
    logic [39:0] keys_a, keys_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    zx_kbd_matrix u_dut_a (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready_a), .ce(ce), .rd(rd), .ad(ad), .aud_in(aud_in),
        .rd_data(rd_data_a), .keys(keys_a)
    );

    zx_kbd_matrix #(
        .IDLE_CLR_CYCLES(100), .CNT_W(8), .EXT_COMBOS(1'b1), .EAR_LEGACY(1'b0), .PAUSE_SKIP(7)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready_b), .ce(ce), .rd(rd), .ad(ad), .aud_in(aud_in),
        .rd_data(rd_data_b), .keys(keys_b)
    );

    // ---------------- reference model ----------------
    // Scancode of each matrix position, in row*5+col order.
    logic [7:0] norm_code [40] = '{
        8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
        8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
        8'h29, 8'h59, 8'h3A, 8'h31, 8'h32
    };
    // Combos: left, down, up, right (extended) and backspace (plain).
    logic [7:0] combo_code  [5] = '{8'h6B, 8'h72, 8'h75, 8'h74, 8'h66};
    bit         combo_ext   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int         combo_digit [5] = '{19, 24, 23, 22, 20};

    bit m_phys [40];
    bit m_virt [5];
    bit m_brk, m_ext;
    int m_skip;

    function automatic int lookup(input bit ext, input logic [7:0] code);
        for (int v = 0; v < 5; v++)
            if (combo_ext[v] == ext && combo_code[v] == code) return 40 + v;
        if (!ext) begin
            for (int i = 0; i < 40; i++)
                if (norm_code[i] == code) return i;
        end else begin
            if (code == 8'h5A) return 30;
            if (code == 8'h14) return 36;
        end
        return -1;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 40; i++) m_phys[i] = 1'b0;
        for (int v = 0; v < 5; v++) m_virt[v] = 1'b0;
    endfunction

    function automatic void m_reset();
        m_clear();
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_skip = 0;
    endfunction

    function automatic void m_apply(input bit set, input bit ext, input logic [7:0] code);
        int k;
        k = lookup(ext, code);
        if (k >= 40) m_virt[k-40] = set;
        else if (k >= 0) m_phys[k] = set;
    endfunction

    function automatic void m_feed(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_brk) begin
            m_apply(1'b0, m_ext, b);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (m_ext) begin
            if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                if (!(b == 8'hE0 || b == 8'hE1 || b == 8'h12 || b == 8'h59))
                    m_apply(1'b1, 1'b1, b);
                m_ext = 1'b0;
            end
        end else begin
            case (b)
                8'hF0:   m_brk = 1'b1;
                8'hE0:   m_ext = 1'b1;
                8'hE1:   m_skip = 7;
                8'hAA:   m_clear();
                default: m_apply(1'b1, 1'b0, b);
            endcase
        end
    endfunction

    function automatic logic [39:0] m_keys();
        logic [39:0] e;
        for (int i = 0; i < 40; i++) e[i] = m_phys[i];
        for (int v = 0; v < 5; v++) begin
            if (m_virt[v]) begin
                e[0] = 1'b1;
                e[combo_digit[v]] = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic logic [4:0] m_row(input logic [7:0] hi, input logic [39:0] e);
        logic [4:0] acc;
        acc = 5'd0;
        for (int r = 0; r < 8; r++)
            if (!hi[r]) acc = acc | e[r*5 +: 5];
        return ~acc;
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the byte is accepted on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        m_feed(b);
    endtask

    task automatic keys_check(input string tag);
        check_eq({tag, "/keys_a"}, {24'd0, keys_a}, {24'd0, m_keys()});
        check_eq({tag, "/keys_b"}, {24'd0, keys_b}, {24'd0, m_keys()});
    endtask

    task automatic rd_check(input string tag, input logic [7:0] hi, input logic [4:0] exp5);
        ad = {hi, 8'hFE};
        ce = 1'b1;
        rd = 1'b1;
        #1;
        check_eq({tag, "/rd_a"}, {56'd0, rd_data_a}, {56'd0, aud_in, 1'b1, aud_in, exp5});
        check_eq({tag, "/rd_b"}, {56'd0, rd_data_b}, {56'd0, 1'b1, aud_in, 1'b1, exp5});
        ce = 1'b0;
        rd = 1'b0;
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 55) return norm_code[$urandom_range(0, 39)];
        if (r < 65) return 8'hF0;
        if (r < 73) return 8'hE0;
        if (r < 80) return combo_code[$urandom_range(0, 4)];
        if (r < 82) return 8'h12;
        if (r < 84) return 8'h59;
        if (r < 86) return 8'hE1;
        if (r < 88) return 8'hAA;
        if (r < 90) return 8'h14;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b, hi, exp_a, exp_b;
        logic [39:0] e;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        ce       = 1'b0;
        rd       = 1'b0;
        ad       = 16'hFFFE;
        aud_in   = 1'b0;
        m_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst/ready_a", {63'd0, rx_ready_a}, 64'd0);
        check_eq("rst/ready_b", {63'd0, rx_ready_b}, 64'd0);
        keys_check("rst");
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst/ready_a_up", {63'd0, rx_ready_a}, 64'd1);
        check_eq("rst/ready_b_up", {63'd0, rx_ready_b}, 64'd1);
        check_eq("rst/idle_bus_a", {56'd0, rd_data_a}, 64'hFF);

        // Single key make/break
        send_byte(8'h15);
        check_eq("t1/q_bit", {63'd0, keys_a[10]}, 64'd1);
        rd_check("t1/q_row", 8'hFB, 5'h1E);
        send_byte(8'hF0); send_byte(8'h15);
        rd_check("t1/q_rel", 8'hFB, 5'h1F);

        // Multi-row AND decode
        send_byte(8'h15); send_byte(8'h16);
        rd_check("t2/two_rows", 8'hF3, 5'h1E);
        rd_check("t2/no_rows", 8'hFF, 5'h1F);
        keys_check("t2");
        send_byte(8'hF0); send_byte(8'h15); send_byte(8'hF0); send_byte(8'h16);

        // Arrow combo alongside held LShift
        send_byte(8'h12); send_byte(8'hE0); send_byte(8'h6B);
        rd_check("t3/cs_row", 8'hFE, 5'h1E);
        rd_check("t3/d5_row", 8'hF7, 5'h0F);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        rd_check("t3/cs_held", 8'hFE, 5'h1E);
        rd_check("t3/d5_rel", 8'hF7, 5'h1F);
        send_byte(8'hF0); send_byte(8'h12);
        rd_check("t3/all_rel", 8'h00, 5'h1F);

        // Pause sequence is swallowed
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        check_eq("t4/pause_none", {24'd0, keys_a}, 64'd0);
        send_byte(8'h1C);
        check_eq("t4/only_a", {24'd0, keys_a}, 64'h20);
        check_eq("t4/only_a_b", {24'd0, keys_b}, 64'h20);
        send_byte(8'hF0); send_byte(8'h1C);

        // Idle clear on instance b (100 cycles)
        send_byte(8'h1A);
        repeat (99) @(negedge clk);
        check_eq("t5/held_99", {24'd0, keys_b}, 64'h2);
        @(negedge clk);
        check_eq("t5/clr_100", {24'd0, keys_b}, 64'h0);
        check_eq("t5/a_no_clr", {24'd0, keys_a}, 64'h2);
        send_byte(8'hAA);
        send_byte(8'h1A);
        repeat (99) @(negedge clk);
        send_byte(8'h22);
        check_eq("t5/byte_wins", {24'd0, keys_b}, 64'h6);
        repeat (99) @(negedge clk);
        check_eq("t5/restart_99", {24'd0, keys_b}, 64'h6);
        @(negedge clk);
        check_eq("t5/restart_clr", {24'd0, keys_b}, 64'h0);
        send_byte(8'hAA);
        keys_check("t5/resync");

        // Reset mid-prefix, BAT clear, EAR bits
        send_byte(8'hF0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        m_reset();
        reset_n = 1'b1;
        @(negedge clk);
        send_byte(8'h1A);
        check_eq("t6/z_make", {24'd0, keys_a}, 64'h2);
        keys_check("t6/z");
        send_byte(8'hAA);
        check_eq("t6/bat_clr", {24'd0, keys_a}, 64'h0);
        aud_in = 1'b1;
        rd_check("t6/ear1", 8'hFF, 5'h1F);
        aud_in = 1'b0;
        rd_check("t6/ear0", 8'hFF, 5'h1F);

        // Randomized byte stream against the model
        for (int i = 0; i < 300; i++) begin
            b = pick_byte();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(b);
            keys_check("rnd");
            hi     = 8'($urandom_range(0, 255));
            ce     = 1'($urandom_range(0, 3) != 0);
            rd     = 1'($urandom_range(0, 3) != 0);
            aud_in = 1'($urandom_range(0, 1));
            ad     = {hi, 8'($urandom_range(0, 255))};
            #1;
            e = m_keys();
            exp_a = (ce && rd) ? {aud_in, 1'b1, aud_in, m_row(hi, e)} : 8'hFF;
            exp_b = (ce && rd) ? {1'b1, aud_in, 1'b1, m_row(hi, e)} : 8'hFF;
            check_eq("rnd/rd_a", {56'd0, rd_data_a}, {56'd0, exp_a});
            check_eq("rnd/rd_b", {56'd0, rd_data_b}, {56'd0, exp_b});
            ce = 1'b0;
            rd = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
